cgra_wb_collector: RTL and testbench
====================================

# cgra_wb_collector

Writeback collector directly downstream of the CGRA output latency pipe. It carries a valid/tag shadow pipeline that matches the data pipe's configured latency. Each data word leaving the pipe is paired with its issue tag and buffered in a small FIFO, which drains to the register-file writeback port under valid/ready. The data pipe cannot stall, so the block issues credits upstream and guarantees that every in-flight result has a FIFO slot.

## Interface
- WIDTH, 32, data word width (same as the data pipe)
- MAX_PIPE_STAGE, 8, maximum configurable latency (same as the data pipe)
- DEPTH, 8, writeback FIFO entries (power of two, ≥2)
- TAG_W, 6, issue tag width (destination register/thread id)
- LAT_W (local), $clog2(MAX_PIPE_STAGE+1) if MAX_PIPE_STAGE>1 else 1
- clk, in, 1, clock
- rst_n, in, 1, reset, asynchronous, active-low
- clr, in, 1, synchronous flush, active high; driven with the same signal as the data pipe's clr
- latency, in, LAT_W, configured latency; same value the data pipe sees
- issue_valid, in, 1, a word enters the data pipe this cycle
- issue_tag, in, TAG_W, tag of the issued word
- issue_ready, out, 1, credit available; upstream issues only when high
- pipe_data, in, WIDTH, data pipe out_data
- wb_valid, out, 1, FIFO head valid
- wb_ready, in, 1, writeback sink accepts
- wb_data, out, WIDTH, head data
- wb_tag, out, TAG_W, head tag
- idle, out, 1, nothing in flight and FIFO empty
- err, out, 2, sticky: [0] issue while !issue_ready, [1] latency changed while in flight

## Operation
- Shadow pipe: MAX_PIPE_STAGE stages of {v, tag}. Shift rule is identical to the data pipe:
  - latency==0: no shift, and the arrival is the current issue (combinational).
  - latency≠0: stage0 <= {issue_valid&accepted, issue_tag}; stage i <= stage i-1 only for i<latency.
  - The arrival is stage[latency-1].
- Accepted issue = issue_valid & issue_ready. An unaccepted issue is not tracked; it sets err[0].
- On arrival, {tag, pipe_data} is pushed into the FIFO that same cycle.
- inflight counter (0..DEPTH): +1 on accepted issue, −1 on arrival with latency≠0. A latency-0 issue never counts as in flight.
- occupancy = inflight + fifo_count. issue_ready = (occupancy < DEPTH), computed from registered state only, with no combinational path from wb_ready.
- FIFO has no bypass. Pop occurs on wb_valid & wb_ready. Push and pop in the same cycle are both performed and the count is unchanged.
- The credit rule guarantees there is never a push into a full FIFO. If one occurs anyway, the word is dropped, and the bench treats this as a failure.
- latency is sampled into lat_q every cycle. If latency≠lat_q while inflight≠0, err[1] is set. Behaviour afterwards is undefined until clr.
- idle = (inflight==0) & (fifo_count==0).

## Timing
- Reset or clr: shadow pipe all-zero, inflight=0, FIFO empty, err=0.
  - Resulting outputs: wb_valid=0, wb_data=0, wb_tag=0, issue_ready=1, idle=1.
- clr takes priority over issue, arrival and pop in the same cycle; all are discarded.
- Issue in cycle T with latency L:
  - arrival (FIFO push) at the clock edge ending cycle T+L;
  - wb_valid high in cycle T+L+1 if the FIFO was empty.
  - L=0 gives wb_valid at T+1.
- issue_ready falls in the cycle after occupancy reaches DEPTH. It rises in the cycle after a pop brings occupancy below DEPTH.
- Simultaneous accepted issue and arrival (L≥1): inflight is unchanged, fifo_count+1.
- FIFO pointers wrap modulo DEPTH. Full is distinguished from empty by a count or an extra pointer bit.
- wb_data and wb_tag hold stable while wb_valid & !wb_ready.

## Test plan
- L=3, DEPTH=8, wb_ready=1; issue tags 1..4 with data 0xA0..0xA3 on consecutive cycles from T=0 -> wb_valid in cycles 4..7 carrying (1,0xA0)..(4,0xA3); idle=1 at cycle 8.
- L=0; issue tag 5 with data 0x55 -> wb_valid next cycle with (5,0x55); inflight stays 0 throughout.
- L=2, wb_ready=0, issue every cycle while issue_ready -> exactly 8 accepted; issue_ready=0 from the cycle after the 8th issue. Raise wb_ready -> order preserved, issue_ready=1 the cycle after the first pop.
- Full FIFO with simultaneous pop and arrival over 20 cycles of random wb_ready at L=5 -> no loss, in-order tags, and occupancy ≤ DEPTH at all times.
- clr asserted while 3 words are in flight and 2 are in the FIFO -> next cycle wb_valid=0, idle=1, issue_ready=1; no stale word ever emerges.
- Issue with issue_ready=0 sets err[0]. Changing L from 3 to 4 with inflight=2 sets err[1]. Both errors clear only on clr or reset.

Source files
------------

// File: rtl/cgra_wb_collector.sv
// Writeback collector: tracks issued words through a valid/tag shadow of the
// data pipe, pairs arrivals with their tags in a FIFO, and issues credits upstream.
module cgra_wb_collector #(
  parameter int WIDTH          = 32,
  parameter int MAX_PIPE_STAGE = 8,
  parameter int DEPTH          = 8,
  parameter int TAG_W          = 6,
  localparam int LAT_W         = (MAX_PIPE_STAGE > 1) ? $clog2(MAX_PIPE_STAGE + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [LAT_W-1:0] latency,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             idle,
  output logic [1:0]       err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [MAX_PIPE_STAGE-1:0] sv_q, sv_d;
  logic [TAG_W-1:0]          stag_q [MAX_PIPE_STAGE];
  logic [TAG_W-1:0]          stag_d [MAX_PIPE_STAGE];
  logic [CNT_W-1:0]          inflight_q, inflight_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]          mem_data_q [DEPTH];
  logic [WIDTH-1:0]          mem_data_d [DEPTH];
  logic [TAG_W-1:0]          mem_tag_q [DEPTH];
  logic [TAG_W-1:0]          mem_tag_d [DEPTH];
  logic [LAT_W-1:0]          lat_q;
  logic [1:0]                err_q, err_d;

  logic             lat_zero;
  logic             accepted;
  logic             arr_v;
  logic [TAG_W-1:0] arr_tag;
  logic             push;
  logic             pop;
  logic             lat_changed;
  logic [CNT_W:0]   occupancy;

  // Credits come only from registered state, so wb_ready never reaches issue_ready.
  assign occupancy   = {1'b0, inflight_q} + {1'b0, count_q};
  assign issue_ready = occupancy < DEPTH_OCC;
  assign accepted    = issue_valid & issue_ready;
  assign lat_zero    = (latency == '0);
  assign wb_valid    = (count_q != '0);
  assign pop         = wb_valid & wb_ready;
  assign push        = arr_v & (count_q != DEPTH_CNT);
  assign lat_changed = (latency != lat_q) && (inflight_q != '0);

  always_comb begin
    arr_v   = 1'b0;
    arr_tag = '0;
    if (lat_zero) begin
      arr_v   = accepted;
      arr_tag = issue_tag;
    end else begin
      for (int i = 0; i < MAX_PIPE_STAGE; i++) begin
        if (int'(latency) == i + 1) begin
          arr_v   = sv_q[i];
          arr_tag = stag_q[i];
        end
      end
    end
  end

  always_comb begin
    sv_d       = sv_q;
    stag_d     = stag_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    err_d      = err_q | {lat_changed, issue_valid & ~issue_ready};
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    // Stages at or beyond the configured latency hold, mirroring the data pipe.
    if (!lat_zero) begin
      sv_d[0]   = accepted;
      stag_d[0] = issue_tag;
      for (int i = 1; i < MAX_PIPE_STAGE; i++) begin
        if (i < int'(latency)) begin
          sv_d[i]   = sv_q[i-1];
          stag_d[i] = stag_q[i-1];
        end
      end
      inflight_d = inflight_q + CNT_W'(accepted) - CNT_W'(arr_v);
    end

    if (push) begin
      mem_data_d[wr_ptr_q] = pipe_data;
      mem_tag_d[wr_ptr_q]  = arr_tag;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (clr) begin
      sv_d       = '0;
      stag_d     = '{default: '0};
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      err_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q       <= '0;
      stag_q     <= '{default: '0};
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lat_q      <= '0;
      err_q      <= '0;
    end else begin
      sv_q       <= sv_d;
      stag_q     <= stag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lat_q      <= latency;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: the outputs are gated by wb_valid.
  always_ff @(posedge clk) begin
    mem_data_q <= mem_data_d;
    mem_tag_q  <= mem_tag_d;
  end

  assign wb_data = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign wb_tag  = wb_valid ? mem_tag_q[rd_ptr_q] : '0;
  assign idle    = (inflight_q == '0) && !wb_valid;
  assign err     = err_q;

endmodule

// File: tb/tb_cgra_wb_collector.sv
// Directed bench for cgra_wb_collector; pipe_data is driven as an ideal data
// pipe replaying each issued word exactly `latency` cycles later.
module tb_cgra_wb_collector;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  latency;
  logic        issue_valid;
  logic [5:0]  issue_tag;
  logic        issue_ready;
  logic [31:0] pipe_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [5:0]  wb_tag;
  logic        idle;
  logic [1:0]  err;

  int          passed;
  int          total;
  int          cyc;
  logic [31:0] hist [0:1023];
  logic [5:0]  exp_q [$];
  int          next_tag;
  int          accepted_cnt;
  int          guard;
  logic        iv;
  logic        wr;
  logic [19:0] ready_pat;

  cgra_wb_collector #(
    .WIDTH(32), .MAX_PIPE_STAGE(8), .DEPTH(8), .TAG_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .latency(latency),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .pipe_data(pipe_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_tag(wb_tag), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  // Drives one cycle of inputs just after a falling edge, then waits for the next one.
  task automatic applyStimulus(input logic v, input logic [5:0] tag, input logic [31:0] data,
                               input logic rdy);
    issue_valid = v;
    issue_tag   = tag;
    wb_ready    = rdy;
    hist[cyc % 1024] = data;
    if (latency == 0) pipe_data = data;
    else if (cyc >= int'(latency)) pipe_data = hist[(cyc - int'(latency)) % 1024];
    else pipe_data = '0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0;
    rst_n = 1'b0; clr = 1'b0; latency = 4'd3;
    issue_valid = 1'b0; issue_tag = '0; pipe_data = '0; wb_ready = 1'b0;
    for (int i = 0; i < 1024; i++) hist[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", 32'(wb_valid), 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_wb_tag", 32'(wb_tag), 0);
    checkOutput("rst_issue_ready", 32'(issue_ready), 1);
    checkOutput("rst_idle", 32'(idle), 1);
    checkOutput("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    $display("[TB] L=3 basic stream");
    for (int c = 0; c < 9; c++) begin
      checkOutput("t1_valid", 32'(wb_valid), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) begin
        checkOutput("t1_tag", 32'(wb_tag), 32'(c - 3));
        checkOutput("t1_data", wb_data, 32'h0000_00A0 + 32'(c - 4));
      end
      if (c == 0 || c == 8) checkOutput("t1_idle", 32'(idle), 1);
      if (c == 1) checkOutput("t1_busy", 32'(idle), 0);
      applyStimulus(c < 4, 6'(c + 1), 32'h0000_00A0 + 32'(c), 1'b1);
    end

    $display("[TB] L=0 passthrough");
    latency = 4'd0;
    applyStimulus(1'b1, 6'd5, 32'h55, 1'b1);
    checkOutput("t2_valid", 32'(wb_valid), 1);
    checkOutput("t2_tag", 32'(wb_tag), 5);
    checkOutput("t2_data", wb_data, 32'h55);
    checkOutput("t2_ready", 32'(issue_ready), 1);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("t2_valid_after", 32'(wb_valid), 0);
    checkOutput("t2_idle_after", 32'(idle), 1);

    $display("[TB] L=2 credit exhaustion");
    latency = 4'd2;
    accepted_cnt = 0; guard = 0;
    while (issue_ready && guard < 20) begin
      applyStimulus(1'b1, 6'(10 + accepted_cnt), 32'h100 + 32'(10 + accepted_cnt), 1'b0);
      accepted_cnt++;
      guard++;
    end
    checkOutput("t3_accepted", 32'(accepted_cnt), 8);
    checkOutput("t3_ready_low", 32'(issue_ready), 0);
    checkOutput("t3_head_tag", 32'(wb_tag), 10);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("t3_hold_tag", 32'(wb_tag), 10);
    checkOutput("t3_hold_data", wb_data, 32'h10A);
    for (int j = 0; j < 8; j++) begin
      checkOutput("t3_drain_valid", 32'(wb_valid), 1);
      checkOutput("t3_drain_tag", 32'(wb_tag), 32'(10 + j));
      checkOutput("t3_drain_data", wb_data, 32'h100 + 32'(10 + j));
      if (j == 0) checkOutput("t3_ready_before_pop", 32'(issue_ready), 0);
      if (j == 1) checkOutput("t3_ready_after_pop", 32'(issue_ready), 1);
      applyStimulus(1'b0, 6'd0, 32'h0, 1'b1);
    end
    checkOutput("t3_empty", 32'(wb_valid), 0);
    checkOutput("t3_idle", 32'(idle), 1);

    $display("[TB] L=5 full FIFO with mixed pops");
    latency = 4'd5;
    next_tag = 20; guard = 0;
    while (issue_ready && guard < 20) begin
      exp_q.push_back(6'(next_tag));
      applyStimulus(1'b1, 6'(next_tag), 32'h200 + 32'(next_tag), 1'b0);
      next_tag++;
      guard++;
    end
    repeat (5) applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("t4_full_ready", 32'(issue_ready), 0);
    ready_pat = 20'b1011_0111_0010_1101_1001;
    for (int i = 0; i < 20; i++) begin
      wr = ready_pat[i];
      iv = issue_ready;
      if (wb_valid) begin
        checkOutput("t4_not_extra", 32'(exp_q.size() > 0), 1);
        checkOutput("t4_tag", 32'(wb_tag), 32'(exp_q[0]));
        checkOutput("t4_data", wb_data, 32'h200 + 32'(exp_q[0]));
        if (wr && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (iv) exp_q.push_back(6'(next_tag));
      checkOutput("t4_occupancy", 32'(exp_q.size() <= 8), 1);
      applyStimulus(iv, 6'(next_tag), 32'h200 + 32'(next_tag), wr);
      if (iv) next_tag++;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (wb_valid) begin
        checkOutput("t4_drain_tag", 32'(wb_tag), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      applyStimulus(1'b0, 6'd0, 32'h0, 1'b1);
      guard++;
    end
    checkOutput("t4_no_loss", 32'(exp_q.size()), 0);
    checkOutput("t4_idle", 32'(idle), 1);
    checkOutput("t4_empty", 32'(wb_valid), 0);

    $display("[TB] clr with words in flight");
    latency = 4'd4;
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 6'(40 + k), 32'h300 + 32'(k), 1'b0);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("t5_pre_valid", 32'(wb_valid), 1);
    checkOutput("t5_pre_tag", 32'(wb_tag), 40);
    checkOutput("t5_pre_idle", 32'(idle), 0);
    clr = 1'b1;
    applyStimulus(1'b1, 6'd50, 32'h350, 1'b1);
    clr = 1'b0;
    checkOutput("t5_valid", 32'(wb_valid), 0);
    checkOutput("t5_idle", 32'(idle), 1);
    checkOutput("t5_ready", 32'(issue_ready), 1);
    checkOutput("t5_tag", 32'(wb_tag), 0);
    checkOutput("t5_data", wb_data, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 6'd0, 32'h0, 1'b1);
      checkOutput("t5_no_stale", 32'(wb_valid), 0);
    end

    $display("[TB] error flags");
    latency = 4'd3;
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 6'(k), 32'h400 + 32'(k), 1'b0);
    checkOutput("t6_ready_low", 32'(issue_ready), 0);
    checkOutput("t6_err_clean", 32'(err), 0);
    applyStimulus(1'b1, 6'd60, 32'h360, 1'b0);
    checkOutput("t6_err0", 32'(err), 1);
    latency = 4'd4;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("t6_err_both", 32'(err), 3);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    checkOutput("t6_err_sticky", 32'(err), 3);
    clr = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0);
    clr = 1'b0;
    checkOutput("t6_err_clr", 32'(err), 0);
    checkOutput("t6_idle_clr", 32'(idle), 1);
    checkOutput("t6_ready_clr", 32'(issue_ready), 1);

    latency = 4'd2;
    applyStimulus(1'b1, 6'd1, 32'h1, 1'b1);
    latency = 4'd3;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("t6_err1_again", 32'(err), 2);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_err_reset", 32'(err), 0);
    checkOutput("t6_idle_reset", 32'(idle), 1);
    checkOutput("t6_ready_reset", 32'(issue_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
